// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter slice.
package mem_bus_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_ADDR,
      WR_DATA,
      WR_RESP
   } arb_state_t;

   typedef enum logic [1:0] {
      NONE,
      IC_RD,
      DC_RD,
      DC_WR
   } arb_grant_t;

   localparam logic [1:0] BUS_SIZE_BYTE = 2'd0;
   localparam logic [1:0] BUS_SIZE_HALF = 2'd1;
   localparam logic [1:0] BUS_SIZE_WORD = 2'd2;

   // Bit positions of the two read requesters in the read arbiter vectors
   localparam int RD_IC = 0;
   localparam int RD_DC = 1;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-input read arbiter (bit 0 = icache, bit 1 = dcache).
// MEM_ARB_RR_EN defined: round-robin, dcache favoured first after reset.
// MEM_ARB_RR_EN undefined: fixed priority, dcache over icache.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant
);

`ifdef MEM_ARB_RR_EN
   // 1 means the dcache won the last read arbitration, so icache goes next
   logic last_rd_grant;

   // Pick the requester that was not served last when both are asking
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last_rd_grant ? 2'b01 : 2'b10;
      end
   end

   // Remember the winner whenever the arbiter actually starts a read
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_rd_grant <= 1'b0;
      end else if (update) begin
         last_rd_grant <= grant[1];
      end
   end
`else
   logic unused_inputs;
   assign unused_inputs = &{1'b0, clk, rst_n, update};

   // Dcache read always beats icache read
   always_comb begin
      grant = 2'b00;
      if (req[1]) begin
         grant = 2'b10;
      end else if (req[0]) begin
         grant = 2'b01;
      end
   end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus among icache reads, dcache reads and
// dcache writes, one transaction at a time. Writes always win; reads are
// arbitrated by rr_arb2 (round-robin when MEM_ARB_RR_EN is defined).
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ic_rd_req,
   input  logic [ADDR_W-1:0] ic_rd_addr,
   input  logic [LEN_W-1:0]  ic_rd_len,
   output logic              ic_rd_ack,
   output logic              ic_rd_valid,
   output logic              ic_rd_last,
   output logic [DATA_W-1:0] ic_rd_data,
   input  logic              dc_rd_req,
   input  logic [ADDR_W-1:0] dc_rd_addr,
   input  logic [LEN_W-1:0]  dc_rd_len,
   input  logic [1:0]        dc_rd_size,
   output logic              dc_rd_ack,
   output logic              dc_rd_valid,
   output logic              dc_rd_last,
   output logic [DATA_W-1:0] dc_rd_data,
   input  logic              dc_wr_req,
   input  logic [ADDR_W-1:0] dc_wr_addr,
   input  logic [LEN_W-1:0]  dc_wr_len,
   input  logic [1:0]        dc_wr_size,
   input  logic [DATA_W/8-1:0] dc_wr_strb,
   input  logic [DATA_W-1:0] dc_wr_data,
   output logic              dc_wr_ack,
   output logic              dc_wr_dready,
   output logic              dc_wr_done,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [LEN_W-1:0]  bus_len,
   output logic [1:0]        bus_size,
   output logic [DATA_W/8-1:0] bus_strb,
   input  logic              bus_addr_ok,
   input  logic              bus_rvalid,
   input  logic              bus_rlast,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              bus_wvalid,
   output logic              bus_wlast,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_wready,
   input  logic              bus_bvalid
);

   localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   arb_state_t          state_q, state_d;
   arb_grant_t          grant_q, grant_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [1:0]          size_q, size_d;
   logic [DATA_W/8-1:0] strb_q, strb_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          rd_req, rd_gnt;
   logic                rd_update;
   logic                beat_last;

   assign rd_req    = {dc_rd_req, ic_rd_req};
   assign beat_last = (cnt_q == len_q);

   rr_arb2 u_rd_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (rd_req),
      .update (rd_update),
      .grant  (rd_gnt)
   );

   // Next-state, field capture and all outputs; everything idles at zero
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      addr_d       = addr_q;
      len_d        = len_q;
      size_d       = size_q;
      strb_d       = strb_q;
      cnt_d        = cnt_q;
      rd_update    = 1'b0;
      ic_rd_ack    = 1'b0;
      ic_rd_valid  = 1'b0;
      ic_rd_last   = 1'b0;
      ic_rd_data   = '0;
      dc_rd_ack    = 1'b0;
      dc_rd_valid  = 1'b0;
      dc_rd_last   = 1'b0;
      dc_rd_data   = '0;
      dc_wr_ack    = 1'b0;
      dc_wr_dready = 1'b0;
      dc_wr_done   = 1'b0;
      bus_req      = 1'b0;
      bus_we       = 1'b0;
      bus_addr     = '0;
      bus_len      = '0;
      bus_size     = '0;
      bus_strb     = '0;
      bus_wvalid   = 1'b0;
      bus_wlast    = 1'b0;
      bus_wdata    = '0;
      case (state_q)
         IDLE: begin
            grant_d = NONE;
            if (dc_wr_req) begin
               grant_d = DC_WR;
               addr_d  = dc_wr_addr;
               len_d   = dc_wr_len;
               size_d  = dc_wr_size;
               strb_d  = dc_wr_strb;
               state_d = WR_ADDR;
            end else if (rd_gnt[RD_DC]) begin
               grant_d   = DC_RD;
               addr_d    = dc_rd_addr;
               len_d     = dc_rd_len;
               size_d    = dc_rd_size;
               strb_d    = '0;
               rd_update = 1'b1;
               state_d   = RD_ADDR;
            end else if (rd_gnt[RD_IC]) begin
               grant_d   = IC_RD;
               addr_d    = ic_rd_addr;
               len_d     = ic_rd_len;
               size_d    = BUS_SIZE_WORD;
               strb_d    = '0;
               rd_update = 1'b1;
               state_d   = RD_ADDR;
            end
         end
         RD_ADDR, WR_ADDR: begin
            bus_req  = 1'b1;
            bus_we   = (state_q == WR_ADDR);
            bus_addr = addr_q;
            bus_len  = len_q;
            bus_size = size_q;
            bus_strb = strb_q;
            if (bus_addr_ok) begin
               ic_rd_ack = (grant_q == IC_RD);
               dc_rd_ack = (grant_q == DC_RD);
               dc_wr_ack = (grant_q == DC_WR);
               cnt_d     = '0;
               state_d   = (state_q == WR_ADDR) ? WR_DATA : RD_DATA;
            end
         end
         RD_DATA: begin
            if (bus_rvalid) begin
               ic_rd_valid = (grant_q == IC_RD);
               ic_rd_last  = (grant_q == IC_RD) && beat_last;
               ic_rd_data  = (grant_q == IC_RD) ? bus_rdata : '0;
               dc_rd_valid = (grant_q == DC_RD);
               dc_rd_last  = (grant_q == DC_RD) && beat_last;
               dc_rd_data  = (grant_q == DC_RD) ? bus_rdata : '0;
               if (beat_last) begin
                  cnt_d   = '0;
                  grant_d = NONE;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         WR_DATA: begin
            bus_wvalid   = 1'b1;
            bus_wlast    = beat_last;
            bus_wdata    = dc_wr_data;
            dc_wr_dready = bus_wready;
            if (bus_wready) begin
               if (beat_last) begin
                  cnt_d   = '0;
                  state_d = WR_RESP;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         WR_RESP: begin
            if (bus_bvalid) begin
               dc_wr_done = 1'b1;
               grant_d    = NONE;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = NONE;
         end
      endcase
   end

   // State, grant, captured request fields and beat counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= NONE;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         strb_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         strb_q  <= strb_d;
         cnt_q   <= cnt_d;
      end
   end

   // The bus's own last flag should agree with our beat counter
   rlast_matches_counter: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == RD_DATA && bus_rvalid) |-> (bus_rlast == beat_last));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter; optional MEM_ARB_RR_EN section
// covers round-robin read alternation.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ic_rd_req, ic_rd_ack, ic_rd_valid, ic_rd_last;
   logic [31:0] ic_rd_addr, ic_rd_data;
   logic [3:0]  ic_rd_len;
   logic        dc_rd_req, dc_rd_ack, dc_rd_valid, dc_rd_last;
   logic [31:0] dc_rd_addr, dc_rd_data;
   logic [3:0]  dc_rd_len;
   logic [1:0]  dc_rd_size;
   logic        dc_wr_req, dc_wr_ack, dc_wr_dready, dc_wr_done;
   logic [31:0] dc_wr_addr, dc_wr_data;
   logic [3:0]  dc_wr_len;
   logic [1:0]  dc_wr_size;
   logic [3:0]  dc_wr_strb;
   logic        bus_req, bus_we, bus_addr_ok, bus_rvalid, bus_rlast;
   logic [31:0] bus_addr, bus_rdata, bus_wdata;
   logic [3:0]  bus_len, bus_strb;
   logic [1:0]  bus_size;
   logic        bus_wvalid, bus_wlast, bus_wready, bus_bvalid;

   int checks = 0;
   int errors = 0;
   int ic_valid_cnt, ic_last_cnt, dc_valid_cnt, dready_cnt, wlast_cnt;
   int bus_req_cnt, done_cnt, ack_n;
   int ack_log [8];

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_len(ic_rd_len),
      .ic_rd_ack(ic_rd_ack), .ic_rd_valid(ic_rd_valid), .ic_rd_last(ic_rd_last),
      .ic_rd_data(ic_rd_data),
      .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_len(dc_rd_len),
      .dc_rd_size(dc_rd_size), .dc_rd_ack(dc_rd_ack), .dc_rd_valid(dc_rd_valid),
      .dc_rd_last(dc_rd_last), .dc_rd_data(dc_rd_data),
      .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_len(dc_wr_len),
      .dc_wr_size(dc_wr_size), .dc_wr_strb(dc_wr_strb), .dc_wr_data(dc_wr_data),
      .dc_wr_ack(dc_wr_ack), .dc_wr_dready(dc_wr_dready), .dc_wr_done(dc_wr_done),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_len(bus_len),
      .bus_size(bus_size), .bus_strb(bus_strb), .bus_addr_ok(bus_addr_ok),
      .bus_rvalid(bus_rvalid), .bus_rlast(bus_rlast), .bus_rdata(bus_rdata),
      .bus_wvalid(bus_wvalid), .bus_wlast(bus_wlast), .bus_wdata(bus_wdata),
      .bus_wready(bus_wready), .bus_bvalid(bus_bvalid)
   );

   // Tally strobes and record the order in which requesters get acked
   always @(negedge clk) begin
      if (ic_rd_valid) ic_valid_cnt++;
      if (ic_rd_valid && ic_rd_last) ic_last_cnt++;
      if (dc_rd_valid) dc_valid_cnt++;
      if (dc_wr_dready) dready_cnt++;
      if (bus_wvalid && bus_wready && bus_wlast) wlast_cnt++;
      if (bus_req) bus_req_cnt++;
      if (dc_wr_done) done_cnt++;
      if (dc_wr_ack && ack_n < 8) begin ack_log[ack_n] = 3; ack_n++; end
      if (dc_rd_ack && ack_n < 8) begin ack_log[ack_n] = 2; ack_n++; end
      if (ic_rd_ack && ack_n < 8) begin ack_log[ack_n] = 1; ack_n++; end
   end

   // Guard against a stuck run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      ic_rd_req = 0; ic_rd_addr = 0; ic_rd_len = 0;
      dc_rd_req = 0; dc_rd_addr = 0; dc_rd_len = 0; dc_rd_size = 0;
      dc_wr_req = 0; dc_wr_addr = 0; dc_wr_len = 0; dc_wr_size = 0;
      dc_wr_strb = 0; dc_wr_data = 0;
      bus_addr_ok = 0; bus_rvalid = 0; bus_rlast = 0; bus_rdata = 0;
      bus_wready = 0; bus_bvalid = 0;
   endtask

   task automatic clear_counts();
      ic_valid_cnt = 0; ic_last_cnt = 0; dc_valid_cnt = 0; dready_cnt = 0;
      wlast_cnt = 0; bus_req_cnt = 0; done_cnt = 0; ack_n = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      idle_inputs();
      step();
      step();
      rst_n = 1;
   endtask

   // One single-beat transaction starting from IDLE with the bus answering at once
   task automatic run_txn(input bit is_wr, input bit drop);
      logic ic_a, dc_a, wr_a;
      sample();
      step();
      bus_addr_ok = 1;
      sample();
      ic_a = ic_rd_ack; dc_a = dc_rd_ack; wr_a = dc_wr_ack;
      step();
      bus_addr_ok = 0;
      if (drop) begin
         if (ic_a) ic_rd_req = 0;
         if (dc_a) dc_rd_req = 0;
         if (wr_a) dc_wr_req = 0;
      end
      if (is_wr) bus_wready = 1;
      else begin bus_rvalid = 1; bus_rlast = 1; end
      sample();
      step();
      bus_wready = 0; bus_rvalid = 0; bus_rlast = 0;
      if (is_wr) begin
         bus_bvalid = 1;
         sample();
         step();
         bus_bvalid = 0;
      end
   endtask

   initial begin
      int  beats;
      logic took;
      clear_counts();

      // Reset with every bus input asserted: outputs must all be zero
      rst_n = 0;
      idle_inputs();
      bus_addr_ok = 1; bus_rvalid = 1; bus_wready = 1; bus_bvalid = 1;
      bus_rdata = 32'hDEAD_BEEF;
      step(); step();
      sample();
      check_output("rst_bus_req", bus_req, 0);
      check_output("rst_ic_valid", ic_rd_valid, 0);
      check_output("rst_ic_data", ic_rd_data, 0);
      check_output("rst_dc_valid", dc_rd_valid, 0);
      check_output("rst_ic_ack", ic_rd_ack, 0);
      check_output("rst_wr_ack", dc_wr_ack, 0);
      check_output("rst_wvalid", bus_wvalid, 0);
      check_output("rst_dready", dc_wr_dready, 0);
      check_output("rst_done", dc_wr_done, 0);
      step();
      idle_inputs();
      rst_n = 1;

      // Stray bus strobes in IDLE are ignored
      bus_rvalid = 1; bus_rdata = 32'h1234_5678; bus_wready = 1;
      sample();
      check_output("stray_ic_valid", ic_rd_valid, 0);
      check_output("stray_dc_valid", dc_rd_valid, 0);
      check_output("stray_dready", dc_wr_dready, 0);
      step();
      idle_inputs();

      // Icache refill, 4 beats
      clear_counts();
      ic_rd_req = 1; ic_rd_addr = 32'h1C00_0000; ic_rd_len = 4'd3;
      sample();
      check_output("ic_req_latency", bus_req, 0);
      step();
      bus_addr_ok = 1;
      sample();
      check_output("ic_bus_req", bus_req, 1);
      check_output("ic_bus_we", bus_we, 0);
      check_output("ic_bus_addr", bus_addr, 32'h1C00_0000);
      check_output("ic_bus_len", bus_len, 3);
      check_output("ic_bus_size", bus_size, 2);
      check_output("ic_ack", ic_rd_ack, 1);
      check_output("ic_no_dc_ack", dc_rd_ack, 0);
      step();
      ic_rd_req = 0; bus_addr_ok = 0;
      for (int k = 0; k < 4; k++) begin
         bus_rvalid = 1; bus_rdata = 32'hA000_0000 + k; bus_rlast = (k == 3);
         sample();
         check_output($sformatf("ic_data_%0d", k), ic_rd_data, 32'hA000_0000 + k);
         check_output($sformatf("ic_last_%0d", k), ic_rd_last, (k == 3));
         step();
      end
      bus_rvalid = 0; bus_rlast = 0;
      sample();
      check_output("ic_valid_count", ic_valid_cnt, 4);
      check_output("ic_last_count", ic_last_cnt, 1);
      check_output("ic_dc_valid_count", dc_valid_cnt, 0);
      check_output("ic_back_idle", bus_req, 0);
      step();

      // Uncached half-word store, single beat
      clear_counts();
      dc_wr_req = 1; dc_wr_addr = 32'h2000_0010; dc_wr_len = 0;
      dc_wr_size = 2'd1; dc_wr_strb = 4'h3; dc_wr_data = 32'hA5A5_1234;
      sample();
      step();
      bus_addr_ok = 1;
      sample();
      check_output("st_bus_we", bus_we, 1);
      check_output("st_bus_addr", bus_addr, 32'h2000_0010);
      check_output("st_bus_size", bus_size, 1);
      check_output("st_bus_strb", bus_strb, 4'h3);
      check_output("st_ack", dc_wr_ack, 1);
      step();
      dc_wr_req = 0; bus_addr_ok = 0; bus_wready = 1;
      sample();
      check_output("st_wvalid", bus_wvalid, 1);
      check_output("st_wlast", bus_wlast, 1);
      check_output("st_wdata", bus_wdata, 32'hA5A5_1234);
      check_output("st_dready", dc_wr_dready, 1);
      step();
      bus_wready = 0;
      sample();
      check_output("st_resp_wvalid", bus_wvalid, 0);
      check_output("st_done_early", dc_wr_done, 0);
      step();
      bus_bvalid = 1;
      sample();
      check_output("st_done", dc_wr_done, 1);
      step();
      bus_bvalid = 0;
      sample();
      check_output("st_dready_count", dready_cnt, 1);
      check_output("st_done_count", done_cnt, 1);
      step();

      // All three requesters at once, fresh from reset
      do_reset();
      clear_counts();
      ic_rd_req = 1; ic_rd_addr = 32'h100; ic_rd_len = 0;
      dc_rd_req = 1; dc_rd_addr = 32'h200; dc_rd_len = 0; dc_rd_size = 2'd2;
      dc_wr_req = 1; dc_wr_addr = 32'h300; dc_wr_len = 0; dc_wr_size = 2'd2;
      dc_wr_strb = 4'hF; dc_wr_data = 32'h33;
      run_txn(1, 1);
      run_txn(0, 1);
      run_txn(0, 1);
      check_output("order_count", ack_n, 3);
      check_output("order_first_wr", ack_log[0], 3);
      check_output("order_second_dc", ack_log[1], 2);
      check_output("order_third_ic", ack_log[2], 1);
      idle_inputs();

`ifdef MEM_ARB_RR_EN
      // Both reads held: grants alternate, dcache first after reset
      do_reset();
      clear_counts();
      ic_rd_req = 1; ic_rd_addr = 32'h400; ic_rd_len = 0;
      dc_rd_req = 1; dc_rd_addr = 32'h500; dc_rd_len = 0; dc_rd_size = 2'd2;
      for (int t = 0; t < 4; t++) run_txn(0, 0);
      check_output("rr_grant_0", ack_log[0], 2);
      check_output("rr_grant_1", ack_log[1], 1);
      check_output("rr_grant_2", ack_log[2], 2);
      check_output("rr_grant_3", ack_log[3], 1);
      idle_inputs();
`endif

      // 8-beat writeback, slow address phase, bus_wready every other cycle
      step();
      clear_counts();
      dc_wr_req = 1; dc_wr_addr = 32'h8000_0000; dc_wr_len = 4'd7;
      dc_wr_size = 2'd2; dc_wr_strb = 4'hF; dc_wr_data = 32'h5000_0000;
      sample();
      step();
      for (int c = 0; c < 5; c++) begin
         bus_addr_ok = (c == 4);
         sample();
         check_output($sformatf("wb_ack_cycle_%0d", c), dc_wr_ack, (c == 4));
         step();
      end
      bus_addr_ok = 0; dc_wr_req = 0;
      beats = 0;
      for (int c = 0; c < 24 && beats < 8; c++) begin
         bus_wready = (c % 2 == 1);
         sample();
         took = dc_wr_dready;
         if (took) begin
            check_output($sformatf("wb_wlast_%0d", beats), bus_wlast, (beats == 7));
            check_output($sformatf("wb_wdata_%0d", beats), bus_wdata, 32'h5000_0000 + beats);
            beats++;
         end
         step();
         if (took) dc_wr_data = 32'h5000_0000 + beats;
      end
      bus_wready = 0;
      check_output("wb_beats", beats, 8);
      check_output("wb_bus_req_cycles", bus_req_cnt, 5);
      check_output("wb_dready_count", dready_cnt, 8);
      check_output("wb_wlast_count", wlast_cnt, 1);
      bus_bvalid = 1;
      sample();
      check_output("wb_done", dc_wr_done, 1);
      step();
      bus_bvalid = 0;

      // Reset in the middle of an icache refill, then a dcache read
      clear_counts();
      ic_rd_req = 1; ic_rd_addr = 32'h1C00_0040; ic_rd_len = 4'd3;
      sample();
      step();
      bus_addr_ok = 1;
      sample();
      step();
      ic_rd_req = 0; bus_addr_ok = 0;
      for (int k = 0; k < 2; k++) begin
         bus_rvalid = 1; bus_rlast = 0; bus_rdata = 32'hB000_0000 + k;
         sample();
         step();
      end
      rst_n = 0;
      sample();
      step();
      rst_n = 1;
      sample();
      check_output("mid_rst_ic_valid", ic_rd_valid, 0);
      check_output("mid_rst_ic_last", ic_rd_last, 0);
      check_output("mid_rst_ic_data", ic_rd_data, 0);
      check_output("mid_rst_bus_req", bus_req, 0);
      step();
      bus_rvalid = 0;
      clear_counts();
      dc_rd_req = 1; dc_rd_addr = 32'h40; dc_rd_len = 4'd1; dc_rd_size = 2'd0;
      sample();
      check_output("post_rst_latency", bus_req, 0);
      step();
      bus_addr_ok = 1;
      sample();
      check_output("post_rst_dc_ack", dc_rd_ack, 1);
      check_output("post_rst_addr", bus_addr, 32'h40);
      check_output("post_rst_size", bus_size, 0);
      check_output("post_rst_len", bus_len, 1);
      step();
      dc_rd_req = 0; bus_addr_ok = 0;
      for (int k = 0; k < 2; k++) begin
         bus_rvalid = 1; bus_rlast = (k == 1); bus_rdata = 32'hC000_0000 + k;
         sample();
         check_output($sformatf("post_rst_dc_data_%0d", k), dc_rd_data, 32'hC000_0000 + k);
         check_output($sformatf("post_rst_dc_last_%0d", k), dc_rd_last, (k == 1));
         check_output($sformatf("post_rst_ic_quiet_%0d", k), ic_rd_valid, 0);
         step();
      end
      bus_rvalid = 0; bus_rlast = 0;
      sample();
      check_output("post_rst_dc_count", dc_valid_cnt, 2);
      check_output("post_rst_idle", bus_req, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
